rf_display: RTL and testbench

Debug display stage that sits directly downstream of the processor's flattened register-file export. It picks one 32-bit register with a one-hot switch word and shows it as hexadecimal on the board's 4-digit multiplexed seven-segment display. The two 16-bit halves are shown alternately. It owns the digit refresh divider, the digit scan, the halfword paging and frame-coherent capture of the selected value, and it drives the `seg` and `an` pins of the board top.

---
 rtl/rf_display_pkg.sv | 22 ++
 rtl/hex7seg.sv | 13 +
 rtl/rf_display.sv | 141 ++++++++++++++
 tb/tb_rf_display.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_display_pkg.sv
// Shared constants for the register-file seven-segment debug display.
// Optional leading-zero blanking is enabled with SEG_BLANK_EN.
package rf_display_pkg;

    localparam int REG_W = 32;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder with blanking.
// Blanking is requested by rf_display when SEG_BLANK_EN is defined.
module hex7seg
    import rf_display_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_OFF : hex_pattern(nib_i);

endmodule

// File: rtl/rf_display.sv
// Register-file debug display: one-hot select, digit scan, halfword paging.
// Define SEG_BLANK_EN for leading-zero blanking of the shown halfword.
module rf_display
    import rf_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int PAGE_DIV    = 100,
    parameter int NREG        = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREG-1:0]       sw,
    input  logic [REG_W*NREG-1:0] rf,
    output logic [6:0]            seg,
    output logic [3:0]            an,
    output logic                  dp,
    output logic                  sel_valid
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam int FW = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(PAGE_DIV - 1);

    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
    logic             page_q, page_d;
    logic [REG_W-1:0] disp_q, disp_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic             sel_valid_q;

    logic             sel_onehot;
    logic [REG_W-1:0] sel_word;
    logic [REG_W-1:0] sel_val;
    logic             tick;
    logic             frame_end;
    logic [15:0]      half;
    logic [3:0]       nib;
    logic             blank;
    logic [6:0]       seg_pat;

    always_comb begin
        sel_onehot = (sw != '0) && ((sw & (sw - NREG'(1))) == '0);
        sel_word   = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sw[i]) begin
                sel_word = sel_word | rf[REG_W*i +: REG_W];
            end
        end
        sel_val = sel_onehot ? sel_word : '0;
    end

    assign tick      = (div_cnt_q == DIV_LAST);
    assign frame_end = tick && (dig_q == 2'd3);

    always_comb begin
        div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
        dig_d       = tick ? dig_q + 2'd1 : dig_q;
        frame_cnt_d = frame_cnt_q;
        page_d      = page_q;
        disp_d      = disp_q;
        // Capture and page flip land together so a frame never mixes values
        if (frame_end) begin
            disp_d = sel_val;
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                page_d      = ~page_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        half = page_q ? disp_q[31:16] : disp_q[15:0];
        nib  = '0;
        case (dig_q)
            2'd0: nib = half[3:0];
            2'd1: nib = half[7:4];
            2'd2: nib = half[11:8];
            2'd3: nib = half[15:12];
            default: nib = '0;
        endcase
        blank = 1'b0;
`ifdef SEG_BLANK_EN
        case (dig_q)
            2'd1: blank = (half[15:4] == '0);
            2'd2: blank = (half[15:8] == '0);
            2'd3: blank = (half[15:12] == '0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    hex7seg u_hex7seg (
        .nib_i   (nib),
        .blank_i (blank),
        .seg_o   (seg_pat)
    );

    always_comb begin
        seg_d = seg_pat;
        an_d  = ~(4'b0001 << dig_q);
        dp_d  = ~(page_q && (dig_q == 2'd3));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            dig_q       <= '0;
            frame_cnt_q <= '0;
            page_q      <= 1'b0;
            disp_q      <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
            dp_q        <= 1'b1;
            sel_valid_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            dig_q       <= dig_d;
            frame_cnt_q <= frame_cnt_d;
            page_q      <= page_d;
            disp_q      <= disp_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
            sel_valid_q <= sel_onehot;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign dp        = dp_q;
    assign sel_valid = sel_valid_q;

endmodule

// File: tb/tb_rf_display.sv
// Scoreboard bench for rf_display at REFRESH_DIV=4, PAGE_DIV=2.
// Honours SEG_BLANK_EN in its expectations when the macro is defined.
module tb_rf_display;

    localparam int RD   = 4;
    localparam int PD   = 2;
    localparam int NREG = 15;

    localparam logic [6:0] TB_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       sv;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREG-1:0]      sw;
    logic [32*NREG-1:0]   rf;
    logic [6:0]           seg;
    logic [3:0]           an;
    logic                 dp;
    logic                 sel_valid;

    int          vectors     = 0;
    int          miscompares = 0;
    int          n           = 0;
    logic [31:0] m_disp      = '0;
    exp_t        sbq [$];

    rf_display #(
        .REFRESH_DIV (RD),
        .PAGE_DIV    (PD),
        .NREG        (NREG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .rf        (rf),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .sel_valid (sel_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_of();
        logic [31:0] r;
        r = '0;
        if ($countones(sw) == 1) begin
            for (int i = 0; i < NREG; i++) begin
                if (sw[i]) r = rf[32*i +: 32];
            end
        end
        return r;
    endfunction

    task automatic step();
        exp_t        e;
        exp_t        got;
        int          d;
        int          pg;
        logic [15:0] h;
        logic [3:0]  nb;
        logic        blank;
        if (reset) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, sv: 1'b0};
        end else begin
            d  = (n / RD) % 4;
            pg = ((n / (4 * RD)) / PD) % 2;
            h  = (pg == 1) ? m_disp[31:16] : m_disp[15:0];
            nb = 4'(h >> (4 * d));
            blank = 1'b0;
`ifdef SEG_BLANK_EN
            if (d > 0 && (h >> (4 * d)) == 16'h0) blank = 1'b1;
`endif
            e.an     = 4'hF;
            e.an[d]  = 1'b0;
            e.seg    = blank ? 7'h7F : TB_HEX[nb];
            e.dp     = !(pg == 1 && d == 3);
            e.sv     = ($countones(sw) == 1);
        end
        sbq.push_back(e);
        if (reset) begin
            n      = 0;
            m_disp = '0;
        end else begin
            if (n % (4 * RD) == 4 * RD - 1) m_disp = sel_of();
            n++;
        end
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check("an",        32'(an),        32'(got.an));
        check("seg",       32'(seg),       32'(got.seg));
        check("dp",        32'(dp),        32'(got.dp));
        check("sel_valid", 32'(sel_valid), 32'(got.sv));
    endtask

    task automatic advance_to(input int tgt);
        for (int k = 0; k < 1000 && n < tgt; k++) step();
    endtask

    initial begin
        reset = 1'b1;
        sw    = '0;
        rf    = '0;
        repeat (3) step();
        check("rst_an",  32'(an),  32'h0000000F);
        check("rst_seg", 32'(seg), 32'h0000007F);

        reset = 1'b0;
        sw    = 15'b1;
        rf[0 +: 32] = 32'h1234ABCD;
        step();
        check("first_an",  32'(an),        32'b1110);
        check("first_seg", 32'(seg),       32'b1000000);
        check("first_sv",  32'(sel_valid), 32'd1);

        advance_to(16);
        step();
        check("lo_d_an",  32'(an),  32'b1110);
        check("lo_d_seg", 32'(seg), 32'b0100001);

        advance_to(32);
        step();
        check("hi_4_seg", 32'(seg), 32'b0011001);
        check("hi_4_dp",  32'(dp),  32'd1);
        advance_to(44);
        step();
        check("hi_1_an",  32'(an),  32'b0111);
        check("hi_1_seg", 32'(seg), 32'b1111001);
        check("hi_1_dp",  32'(dp),  32'd0);

        advance_to(64);
        step();
        check("back_lo_seg", 32'(seg), 32'b0100001);
        check("back_lo_dp",  32'(dp),  32'd1);

        sw = 15'b11;
        step();
        check("inval_sv", 32'(sel_valid), 32'd0);
        advance_to(80);
        step();
        check("inval_seg", 32'(seg), 32'b1000000);

        sw = 15'b10;
        rf[32*1 +: 32] = 32'h11111111;
        rf[32*3 +: 32] = 32'h33333333;
        advance_to(100);
        sw = 15'b1000;
        step();
        check("mid_old_seg", 32'(seg), 32'b1111001);
        advance_to(112);
        step();
        check("mid_new_seg", 32'(seg), 32'b0110000);

        advance_to(137);
        step();
        reset = 1'b1;
        step();
        check("mrst_an",  32'(an),        32'h0000000F);
        check("mrst_seg", 32'(seg),       32'h0000007F);
        check("mrst_dp",  32'(dp),        32'd1);
        check("mrst_sv",  32'(sel_valid), 32'd0);

        reset = 1'b0;
        sw    = 15'b1;
        rf[0 +: 32] = 32'h000000A5;
        advance_to(16);
        step();
        check("a5_d0_seg", 32'(seg), 32'b0010010);
        advance_to(24);
        step();
        check("a5_d2_an", 32'(an), 32'b1011);
`ifdef SEG_BLANK_EN
        check("a5_d2_seg", 32'(seg), 32'b1111111);
`else
        check("a5_d2_seg", 32'(seg), 32'b1000000);
`endif
        advance_to(28);
        step();
        check("a5_d3_an", 32'(an), 32'b0111);
`ifdef SEG_BLANK_EN
        check("a5_d3_seg", 32'(seg), 32'b1111111);
`else
        check("a5_d3_seg", 32'(seg), 32'b1000000);
`endif
        advance_to(40);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
